// File: rtl/blood_bank_dispenser.sv
// Blood-bank dispenser: searches per-type stock for a donor compatible with the
// requested recipient type, reserves one unit, and reports the granted donor code.
module blood_bank_dispenser #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             add_valid,
  input  logic [2:0]       add_type,
  output logic             add_overflow,
  input  logic             req_valid,
  input  logic [2:0]       req_type,
  output logic             req_ready,
  output logic             resp_valid,
  output logic             resp_granted,
  output logic [2:0]       resp_type,
  input  logic [2:0]       rd_type,
  output logic [CNT_W-1:0] rd_count
);

  localparam int unsigned NUM_TYPES = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t stateQ, stateD;
  logic [2:0] recipQ, recipD;
  logic [2:0] cursorQ, cursorD;
  logic grantQ, grantD;
  logic [2:0] respTypeQ, respTypeD;
  logic readyQ, respValidQ, overflowQ;
  logic [CNT_W-1:0] countQ [NUM_TYPES];

  logic compat;
  logic hit;
  logic [NUM_TYPES-1:0] addSel, decSel, atMax;

  // A donor may only carry antigens the recipient also has.
  assign compat = ((cursorQ & ~recipQ) == 3'b000);

  // Next-state and search control.
  always_comb begin
    stateD    = stateQ;
    recipD    = recipQ;
    cursorD   = cursorQ;
    grantD    = grantQ;
    respTypeD = respTypeQ;
    hit       = 1'b0;
    case (stateQ)
      IDLE: begin
        if (req_valid) begin
          recipD  = req_type;
          cursorD = req_type;
          stateD  = SCAN;
        end
      end
      SCAN: begin
        if (compat && (countQ[cursorQ] != '0)) begin
          hit       = 1'b1;
          grantD    = 1'b1;
          respTypeD = cursorQ;
          stateD    = RESP;
        end else if (cursorQ == 3'b000) begin
          grantD    = 1'b0;
          respTypeD = 3'b000;
          stateD    = RESP;
        end else begin
          cursorD = cursorQ - 3'd1;
        end
      end
      RESP:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Per-type add/decrement selects; a simultaneous add and reserve cancel out.
  always_comb begin
    addSel = '0;
    decSel = '0;
    atMax  = '0;
    for (int i = 0; i < NUM_TYPES; i++) begin
      addSel[i] = add_valid && (add_type == 3'(i));
      decSel[i] = hit && (cursorQ == 3'(i));
      atMax[i]  = (countQ[i] == CNT_MAX);
    end
  end

  // FSM state and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= IDLE;
      recipQ     <= 3'b000;
      cursorQ    <= 3'b000;
      grantQ     <= 1'b0;
      respTypeQ  <= 3'b000;
      readyQ     <= 1'b1;
      respValidQ <= 1'b0;
    end else begin
      stateQ     <= stateD;
      recipQ     <= recipD;
      cursorQ    <= cursorD;
      grantQ     <= grantD;
      respTypeQ  <= respTypeD;
      readyQ     <= (stateD == IDLE);
      respValidQ <= (stateD == RESP);
    end
  end

  // Stock counters, saturating on add.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TYPES; i++) countQ[i] <= '0;
      overflowQ <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_TYPES; i++) begin
        if (addSel[i] && !decSel[i] && !atMax[i]) begin
          countQ[i] <= countQ[i] + CNT_W'(1);
        end else if (decSel[i] && !addSel[i]) begin
          countQ[i] <= countQ[i] - CNT_W'(1);
        end
      end
      overflowQ <= |(addSel & ~decSel & atMax);
    end
  end

  assign req_ready    = readyQ;
  assign resp_valid   = respValidQ;
  assign resp_granted = grantQ;
  assign resp_type    = respTypeQ;
  assign add_overflow = overflowQ;
  assign rd_count     = countQ[rd_type];

endmodule

// File: tb/tb_blood_bank_dispenser.sv
// Scoreboard bench for blood_bank_dispenser: requests push expected responses,
// a negedge monitor pops and checks grant, donor type and arrival cycle.
module tb_blood_bank_dispenser;

  localparam int unsigned TB_W = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            add_valid = 1'b0;
  logic [2:0]      add_type = 3'b000;
  logic            add_overflow;
  logic            req_valid = 1'b0;
  logic [2:0]      req_type = 3'b000;
  logic            req_ready;
  logic            resp_valid;
  logic            resp_granted;
  logic [2:0]      resp_type;
  logic [2:0]      rd_type = 3'b000;
  logic [TB_W-1:0] rd_count;

  typedef struct {
    logic       g;
    logic [2:0] t;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   nCmp = 0;
  int   nBad = 0;

  blood_bank_dispenser #(.CNT_W(TB_W)) dut (
    .clk(clk), .rst(rst),
    .add_valid(add_valid), .add_type(add_type), .add_overflow(add_overflow),
    .req_valid(req_valid), .req_type(req_type), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_granted(resp_granted), .resp_type(resp_type),
    .rd_type(rd_type), .rd_count(rd_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_granted", 32'(resp_granted), 32'(e.g));
        check("resp_type", 32'(resp_type), 32'(e.t));
        check("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic addUnit(input logic [2:0] t);
    add_valid = 1'b1;
    add_type  = t;
    @(posedge clk);
    #1 add_valid = 1'b0;
  endtask

  task automatic chkCount(input string name, input logic [2:0] t, input int exp);
    rd_type = t;
    #1 check(name, 32'(rd_count), 32'(exp));
  endtask

  task automatic chkAllZero();
    for (int i = 0; i < 8; i++) chkCount("count_zero", 3'(i), 0);
    @(posedge clk);
    #1;
  endtask

  // Issue one request; lat counts cycles from the accept edge to resp_valid.
  task automatic doReq(input logic [2:0] t, input bit push, input logic g,
                       input logic [2:0] et, input int lat);
    for (int k = 0; k < 50 && !req_ready; k++) begin
      @(posedge clk);
      #1;
    end
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_type  = t;
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (push) sb.push_back('{g, et, cyc + lat - 1});
  endtask

  task automatic waitDone();
    for (int k = 0; k < 60 && (sb.size() != 0 || !req_ready); k++) begin
      @(posedge clk);
      #1;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    // Reset state.
    doReset();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_granted", 32'(resp_granted), 32'd0);
    check("rst_resp_type", 32'(resp_type), 32'd0);
    check("rst_add_overflow", 32'(add_overflow), 32'd0);
    chkAllZero();

    // Exact-type hit.
    addUnit(3'b011);
    addUnit(3'b011);
    chkCount("count_aplus_2", 3'b011, 2);
    doReq(3'b011, 1'b1, 1'b1, 3'b011, 2);
    waitDone();
    chkCount("count_aplus_1", 3'b011, 1);

    // Universal donor found last, then denial once exhausted.
    doReset();
    addUnit(3'b000);
    doReq(3'b111, 1'b1, 1'b1, 3'b000, 9);
    waitDone();
    doReq(3'b111, 1'b1, 1'b0, 3'b000, 9);
    waitDone();
    chkCount("count_oneg_0", 3'b000, 0);

    // ABO-incompatible stock only.
    doReset();
    repeat (3) addUnit(3'b101);
    doReq(3'b010, 1'b1, 1'b0, 3'b000, 4);
    waitDone();
    chkCount("count_bplus_3", 3'b101, 3);

    // Descending order prefers A- over O+ for an A+ recipient.
    doReset();
    addUnit(3'b010);
    addUnit(3'b001);
    doReq(3'b011, 1'b1, 1'b1, 3'b010, 3);
    waitDone();
    chkCount("count_aneg_0", 3'b010, 0);
    chkCount("count_opos_1", 3'b001, 1);

    // Rh+ donor refused to Rh- recipient.
    doReset();
    addUnit(3'b001);
    doReq(3'b010, 1'b1, 1'b0, 3'b000, 4);
    waitDone();
    chkCount("count_opos_kept", 3'b001, 1);

    // Saturation and overflow pulse.
    doReset();
    repeat (3) addUnit(3'b001);
    check("no_ovf_below_max", 32'(add_overflow), 32'd0);
    chkCount("count_opos_max", 3'b001, 3);
    addUnit(3'b001);
    check("ovf_pulse", 32'(add_overflow), 32'd1);
    chkCount("count_opos_sat", 3'b001, 3);
    @(posedge clk);
    #1 check("ovf_one_cycle", 32'(add_overflow), 32'd0);

    // Add and hit on the same type in the same cycle: net zero, no overflow.
    doReq(3'b001, 1'b1, 1'b1, 3'b001, 2);
    addUnit(3'b001);
    check("no_ovf_add_and_hit", 32'(add_overflow), 32'd0);
    waitDone();
    chkCount("count_opos_net0", 3'b001, 3);

    // Reset during scan: no response, ready again, stock cleared.
    doReset();
    addUnit(3'b000);
    doReq(3'b111, 1'b0, 1'b0, 3'b000, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 check("midscan_rst_ready", 32'(req_ready), 32'd1);
    check("midscan_rst_no_resp", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1 chkAllZero();
    check("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/blood_bank_dispenser.md
Name: blood_bank_dispenser

Overview:
- Inventory-side partner of the blood-type classifier. The classifier maps a donor code to a class; this block runs the other way.
- Given a recipient type, it searches per-type unit stock for a compatible donor type, reserves one unit, and returns the granted donor code.
- It sits between the ward request logic and the stock-keeping inputs of the blood-bank system.

Parameters:
- CNT_W, 8, width of each per-type unit counter; counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- add_valid  input  1  add one unit of add_type to stock this cycle.
- add_type  input  3  blood-type code of the unit being added.
- add_overflow  output  1  1-cycle pulse when an add is dropped because that counter is at max.
- req_valid  input  1  recipient request present.
- req_type  input  3  recipient blood-type code.
- req_ready  output  1  block can accept a request (high only in IDLE).
- resp_valid  output  1  1-cycle pulse carrying the result.
- resp_granted  output  1  1 = a unit was reserved; 0 = no compatible stock.
- resp_type  output  3  donor code reserved; 3'b000 when denied.
- rd_type  input  3  stock query select.
- rd_count  output  CNT_W  combinational read of the counter for rd_type.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Code format: bits [2:1] are the ABO group (00=O, 01=A, 10=B, 11=AB); bit [0] is Rh (1=positive).
- Compatibility: donor d is compatible with recipient r iff (d & ~r) == 3'b000. All compatible donors therefore have numeric value <= r.
- Reset values: all 8 counters = 0, state = IDLE, req_ready = 1, resp_valid = 0, resp_granted = 0, resp_type = 0, add_overflow = 0.
- FSM states: IDLE, SCAN, RESP.
- IDLE: req_ready = 1. When req_valid = 1 at an edge, capture req_type into recip and set cursor = req_type. Next state is SCAN.
- SCAN: req_ready = 0. Each cycle, test cursor using the registered count value.
  - Hit: compatible(cursor, recip) and count[cursor] > 0. Decrement count[cursor] and latch resp_type = cursor, resp_granted = 1. Next state is RESP.
  - Miss with cursor == 0: latch resp_granted = 0, resp_type = 0. Next state is RESP.
  - Otherwise: cursor = cursor - 1; stay in SCAN.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. resp_granted and resp_type hold their values until the next RESP.
- Latency: request accepted at edge T; an exact-type hit gives resp_valid during cycle T+2. Each skipped code adds 1 cycle. Worst case (AB+ recipient, deny) gives resp_valid during cycle T+9.
- Search order: descending code from recip. Exact match is always preferred; O- (000) is always tried last.
- Add path: independent of the FSM and active in every state.
  - Counter < max: add increments it.
  - Counter at max: add is dropped and add_overflow pulses on the following cycle.
- Same-cycle add and hit-decrement on the same type: the net change is 0. A counter at max does not overflow in this case, and add_overflow stays 0.
- Same-cycle add to a different type: both updates apply.
- A unit added while a scan has already passed that code is not seen by the current request.
- req_valid while not in IDLE is ignored; the requester must hold req_valid until req_ready.
- rst asserted mid-scan: the FSM returns to IDLE, no response is issued, and all stock is cleared.
- rd_count reflects the registered count, so an update appears the cycle after its edge.

Test Plan:
- Reset, then add 2 units of A+ (011). Request A+ -> resp_valid at T+2, granted = 1, type = 011; rd_count(011) = 1.
- Stock only O- (000) = 1. Request AB+ (111) -> granted = 1, type = 000, resp_valid at T+9; a second AB+ request gets granted = 0, type = 000.
- Stock only B+ (101) = 3. Request A- (010) -> denied (B not compatible); count(101) stays 3.
- Stock A- = 1 and O+ = 1. Request A+ -> type = 010, since descending order hits A- first. Stock O+ = 1, no A-, and request A- -> denied (Rh+ donor to Rh- recipient).
- CNT_W = 2: add 4 units of O+ -> the 4th add gives an add_overflow pulse and count = 3.
  - With count = 3 and a hit on O+, add O+ in the same cycle -> count stays 3 and no overflow.
- Start an AB+ scan with empty stock, assert rst on the 3rd SCAN cycle -> no resp_valid, req_ready = 1 the next cycle, all counts = 0.
